// File: rtl/exec_pipe_if.sv
// rtl/exec_pipe_if.sv - decoded-instruction bus into the execute pipeline, plus flags and retire status
interface exec_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RAW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [RAW-1:0]  rs1;
  logic [RAW-1:0]  rs2;
  logic [RAW-1:0]  rd;
  logic            RegWrite;
  logic            ALUSrc;
  logic [3:0]      ALUControl;
  logic [XLEN-1:0] ImmExt;
  logic            MemWrite;
  logic [XLEN-1:0] PCPlus4;
  logic            LoadSign;
  logic [1:0]      SizeSrc;
  logic [1:0]      ResultSrc;
  logic            Zero;
  logic            signedLess;
  logic            unsignedLess;
  logic            retire_valid;
  logic [XLEN-1:0] a0;

  modport master (
    output in_valid, rs1, rs2, rd, RegWrite, ALUSrc, ALUControl, ImmExt,
           MemWrite, PCPlus4, LoadSign, SizeSrc, ResultSrc,
    input  in_ready, Zero, signedLess, unsignedLess, retire_valid, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, RegWrite, ALUSrc, ALUControl, ImmExt,
           MemWrite, PCPlus4, LoadSign, SizeSrc, ResultSrc,
    output in_ready, Zero, signedLess, unsignedLess, retire_valid, a0
  );
endinterface

// File: rtl/exec_pipe.sv
// rtl/exec_pipe.sv - E/M/W datapath with register file, ALU, byte-addressed data memory,
// operand forwarding and a one-cycle load-use stall.
module exec_pipe #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_WORDS = 1024,
  parameter int A0_IDX     = 10
) (
  input  logic       clk,
  input  logic       rst,
  exec_pipe_if.slave bus
);
  localparam int RAW    = $clog2(NREGS);
  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int IDXW   = $clog2(DMEM_WORDS);
  localparam int SHW    = $clog2(XLEN);

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memwrite;
    logic            loadsign;
    logic [RAW-1:0]  rd;
    logic [1:0]      size;
    logic [1:0]      rsrc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] wdata;
  } m_stage_t;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            loadsign;
    logic [RAW-1:0]  rd;
    logic [1:0]      size;
    logic [1:0]      rsrc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rdata;
  } w_stage_t;

  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;

  logic [XLEN-1:0] rf_q  [NREGS];
  logic [XLEN-1:0] mem_q [DMEM_WORDS];

  logic [OFFW-1:0]   w_off, m_off;
  logic [XLEN-1:0]   w_shifted, w_load, w_result, m_fwd;
  logic [XLEN-1:0]   rs1_val, rs2_val, src_a, src_b, alu_y;
  logic [SHW-1:0]    shamt;
  logic              lt_s, lt_u, stall, rf_we, mem_we;
  logic [IDXW-1:0]   m_idx;
  logic [NBYTES-1:0] m_be;
  logic [XLEN-1:0]   m_wword;

  // Word accesses ignore the offset, halves round it down to even, bytes use it whole.
  function automatic logic [OFFW-1:0] eff_off(input logic [OFFW-1:0] lo, input logic [1:0] sz);
    logic [OFFW-1:0] o;
    o = lo;
    if (sz[1]) o = '0;
    else if (sz[0]) o[0] = 1'b0;
    return o;
  endfunction

  always_comb begin
    w_off     = eff_off(w_q.alu[OFFW-1:0], w_q.size);
    w_shifted = w_q.rdata >> {w_off, 3'b000};
    case (w_q.size)
      SZ_BYTE: w_load = {{(XLEN-8){w_q.loadsign & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = {{(XLEN-16){w_q.loadsign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
    case (w_q.rsrc)
      RES_MEM: w_result = w_load;
      RES_PC4: w_result = w_q.pc4;
      default: w_result = w_q.alu;
    endcase
    m_fwd = (m_q.rsrc == RES_PC4) ? m_q.pc4 : m_q.alu;
  end

  // M beats W beats the register file; rd = x0 never forwards.
  always_comb begin
    rs1_val = (bus.rs1 == '0) ? '0 : rf_q[bus.rs1];
    if (m_q.valid && m_q.regwrite && (m_q.rd != '0) && (m_q.rd == bus.rs1))
      rs1_val = m_fwd;
    else if (w_q.valid && w_q.regwrite && (w_q.rd != '0) && (w_q.rd == bus.rs1))
      rs1_val = w_result;

    rs2_val = (bus.rs2 == '0) ? '0 : rf_q[bus.rs2];
    if (m_q.valid && m_q.regwrite && (m_q.rd != '0) && (m_q.rd == bus.rs2))
      rs2_val = m_fwd;
    else if (w_q.valid && w_q.regwrite && (w_q.rd != '0) && (w_q.rd == bus.rs2))
      rs2_val = w_result;

    src_a = rs1_val;
    src_b = bus.ALUSrc ? bus.ImmExt : rs2_val;
    shamt = src_b[SHW-1:0];
    lt_s  = $signed(src_a) < $signed(src_b);
    lt_u  = src_a < src_b;
  end

  always_comb begin
    case (bus.ALUControl)
      4'b0000: alu_y = src_a + src_b;
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a & src_b;
      4'b0011: alu_y = src_a | src_b;
      4'b0100: alu_y = src_a ^ src_b;
      4'b0101: alu_y = {{(XLEN-1){1'b0}}, lt_s};
      4'b0110: alu_y = {{(XLEN-1){1'b0}}, lt_u};
      4'b0111: alu_y = src_a << shamt;
      4'b1000: alu_y = src_a >> shamt;
      4'b1001: alu_y = $signed(src_a) >>> shamt;
      4'b1010: alu_y = src_b;
      default: alu_y = '0;
    endcase
  end

  // A load in M cannot forward its data yet, so a dependent instruction waits one cycle.
  always_comb begin
    stall = !rst && bus.in_valid && m_q.valid && m_q.regwrite && (m_q.rsrc == RES_MEM) &&
            (m_q.rd != '0) && ((bus.rs1 == m_q.rd) || (bus.rs2 == m_q.rd));

    m_d.valid    = bus.in_valid && !stall;
    m_d.regwrite = bus.RegWrite;
    m_d.memwrite = bus.MemWrite;
    m_d.loadsign = bus.LoadSign;
    m_d.rd       = bus.rd;
    m_d.size     = bus.SizeSrc;
    m_d.rsrc     = bus.ResultSrc;
    m_d.alu      = alu_y;
    m_d.pc4      = bus.PCPlus4;
    m_d.wdata    = rs2_val;

    m_off   = eff_off(m_q.alu[OFFW-1:0], m_q.size);
    m_idx   = m_q.alu[OFFW +: IDXW];
    m_wword = m_q.wdata << {m_off, 3'b000};
    case (m_q.size)
      SZ_BYTE: m_be = {{(NBYTES-1){1'b0}}, 1'b1} << m_off;
      SZ_HALF: m_be = {{(NBYTES-2){1'b0}}, 2'b11} << m_off;
      default: m_be = '1;
    endcase
    mem_we = !rst && m_q.valid && m_q.memwrite;

    w_d.valid    = m_q.valid;
    w_d.regwrite = m_q.regwrite;
    w_d.loadsign = m_q.loadsign;
    w_d.rd       = m_q.rd;
    w_d.size     = m_q.size;
    w_d.rsrc     = m_q.rsrc;
    w_d.alu      = m_q.alu;
    w_d.pc4      = m_q.pc4;
    w_d.rdata    = mem_q[m_idx];

    rf_we = w_q.valid && w_q.regwrite && (w_q.rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[w_q.rd] <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++)
        if (m_be[b]) mem_q[m_idx][8*b +: 8] <= m_wword[8*b +: 8];
    end
  end

  assign bus.in_ready     = !stall;
  assign bus.Zero         = (src_a == src_b);
  assign bus.signedLess   = lt_s;
  assign bus.unsignedLess = lt_u;
  assign bus.retire_valid = w_q.valid && !rst;
  assign bus.a0           = rf_q[A0_IDX];
endmodule

// File: tb/tb_exec_pipe.sv
// tb/tb_exec_pipe.sv - directed and randomized checks of exec_pipe against an architectural model
module tb_exec_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_pipe_if #(.XLEN(32), .NREGS(32)) bus ();
  exec_pipe #(.XLEN(32), .NREGS(32), .DMEM_WORDS(1024), .A0_IDX(10)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, alusrc, memwrite, loadsign;
    logic [3:0]  aluc;
    logic [31:0] imm, pc4;
    logic [1:0]  size, rsrc;
  } instr_t;

  logic [31:0] mr [32];
  logic [7:0]  mb [4096];

  function automatic instr_t alu_rr(input logic [4:0] rd, rs1, rs2, input logic [3:0] c);
    instr_t i = '0;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.aluc = c; i.regwrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t alu_ri(input logic [4:0] rd, rs1, input logic [31:0] imm, input logic [3:0] c);
    instr_t i = '0;
    i.rd = rd; i.rs1 = rs1; i.imm = imm; i.aluc = c; i.alusrc = 1'b1; i.regwrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t ld(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] sz, input logic sgn);
    instr_t i = alu_ri(rd, 5'd0, addr, 4'b0000);
    i.rsrc = 2'b01; i.size = sz; i.loadsign = sgn;
    return i;
  endfunction

  function automatic instr_t st(input logic [4:0] rs2, input logic [31:0] addr, input logic [1:0] sz);
    instr_t i = alu_ri(5'd0, 5'd0, addr, 4'b0000);
    i.regwrite = 1'b0; i.memwrite = 1'b1; i.rs2 = rs2; i.size = sz;
    return i;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $signed(a) >>> b[4:0];
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn);
    int base;
    base = int'(addr[11:0]);
    case (sz)
      2'b00: return {{24{sgn & mb[base][7]}}, mb[base]};
      2'b01: begin
        base = base & ~1;
        return {{16{sgn & mb[base+1][7]}}, mb[base+1], mb[base]};
      end
      default: begin
        base = base & ~3;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
      end
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
    int base;
    int n;
    base = int'(addr[11:0]);
    n = 4;
    if (sz == 2'b00) n = 1;
    else if (sz == 2'b01) begin n = 2; base = base & ~1; end
    else base = base & ~3;
    for (int k = 0; k < n; k++) mb[base+k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : mr[r];
  endfunction

  task automatic model_exec(input instr_t i);
    logic [31:0] b, r;
    b = i.alusrc ? i.imm : reg_val(i.rs2);
    r = model_alu(i.aluc, reg_val(i.rs1), b);
    if (i.memwrite) model_store(r, i.size, reg_val(i.rs2));
    if (i.regwrite && i.rd != 5'd0) begin
      case (i.rsrc)
        2'b01:   mr[i.rd] = model_load(r, i.size, i.loadsign);
        2'b10:   mr[i.rd] = i.pc4;
        default: mr[i.rd] = r;
      endcase
    end
  endtask

  task automatic drive(input instr_t i, input logic v);
    bus.in_valid = v;      bus.rs1 = i.rs1;        bus.rs2 = i.rs2;     bus.rd = i.rd;
    bus.RegWrite = i.regwrite; bus.ALUSrc = i.alusrc; bus.ALUControl = i.aluc;
    bus.ImmExt = i.imm;    bus.MemWrite = i.memwrite; bus.PCPlus4 = i.pc4;
    bus.LoadSign = i.loadsign; bus.SizeSrc = i.size; bus.ResultSrc = i.rsrc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_t i);
    int guard = 0;
    drive(i, 1'b1);
    @(negedge clk);
    while (!bus.in_ready && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
    end
    tick();
    drive('0, 1'b0);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    issue(alu_rr(5'd10, r, 5'd0, 4'b0000));
    repeat (3) tick();
    v = bus.a0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b required 1", bus.in_ready); end
    n_tests++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire got=%b required 0", bus.retire_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.a0 !== 32'd0) begin n_fail++; $display("FAIL reset_a0 got=%h required 0", bus.a0); end
    n_tests++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_retire got=%b required 0", bus.retire_valid); end
    tick();
  endtask

  task automatic test_addi_a0();
    drive(alu_ri(5'd10, 5'd0, 32'd5, 4'b0000), 1'b1);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got=%b required 1", bus.in_ready); end
    tick(); drive('0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL addi_retire_early got=%b required 0", bus.retire_valid); end
    tick(); @(negedge clk);
    n_tests++; if (bus.retire_valid !== 1'b1) begin n_fail++; $display("FAIL addi_retire got=%b required 1", bus.retire_valid); end
    n_tests++; if (bus.a0 !== 32'd0) begin n_fail++; $display("FAIL addi_a0_early got=%h required 0", bus.a0); end
    tick(); @(negedge clk);
    n_tests++; if (bus.a0 !== 32'd5) begin n_fail++; $display("FAIL addi_a0 got=%h required 5", bus.a0); end
    tick();
  endtask

  task automatic test_forward();
    logic [31:0] v;
    drive(alu_ri(5'd1, 5'd0, 32'd7, 4'b0000), 1'b1);
    tick();
    drive(alu_rr(5'd2, 5'd1, 5'd1, 4'b0001), 1'b1);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got=%b required 1", bus.in_ready); end
    n_tests++; if (bus.Zero !== 1'b1) begin n_fail++; $display("FAIL fwd_zero got=%b required 1", bus.Zero); end
    tick();
    issue(alu_rr(5'd10, 5'd1, 5'd2, 4'b0000));
    repeat (3) tick();
    n_tests++; if (bus.a0 !== 32'd7) begin n_fail++; $display("FAIL fwd_x1_plus_x2 got=%h required 7", bus.a0); end
    read_reg(5'd2, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL fwd_x2 got=%h required 0", v); end
  endtask

  task automatic test_loads();
    logic [31:0] v;
    issue(alu_ri(5'd7, 5'd0, 32'hA1B2C3D4, 4'b0000));
    issue(st(5'd7, 32'd8, 2'b10));
    issue(ld(5'd3, 32'd9, 2'b00, 1'b0));
    issue(ld(5'd4, 32'd11, 2'b00, 1'b1));
    issue(ld(5'd5, 32'd10, 2'b01, 1'b1));
    read_reg(5'd3, v);
    n_tests++; if (v !== 32'h000000C3) begin n_fail++; $display("FAIL lbu_x3 got=%h required 000000c3", v); end
    read_reg(5'd4, v);
    n_tests++; if (v !== 32'hFFFFFFA1) begin n_fail++; $display("FAIL lb_x4 got=%h required ffffffa1", v); end
    read_reg(5'd5, v);
    n_tests++; if (v !== 32'hFFFFA1B2) begin n_fail++; $display("FAIL lh_x5 got=%h required ffffa1b2", v); end
  endtask

  task automatic test_load_use();
    drive(ld(5'd6, 32'd8, 2'b10, 1'b0), 1'b1);
    tick();
    drive(alu_rr(5'd10, 5'd6, 5'd0, 4'b0000), 1'b1);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall got=%b required 0", bus.in_ready); end
    tick(); @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_release got=%b required 1", bus.in_ready); end
    tick(); drive('0, 1'b0);
    repeat (3) tick();
    n_tests++; if (bus.a0 !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL loaduse_a0 got=%h required a1b2c3d4", bus.a0); end
  endtask

  task automatic test_compare_shift();
    issue(alu_ri(5'd1, 5'd0, 32'hFFFFFFFF, 4'b0000));
    issue(alu_ri(5'd2, 5'd0, 32'd1, 4'b0000));
    drive(alu_rr(5'd10, 5'd1, 5'd2, 4'b0101), 1'b1);
    @(negedge clk);
    n_tests++; if (bus.signedLess !== 1'b1) begin n_fail++; $display("FAIL slt_flag got=%b required 1", bus.signedLess); end
    n_tests++; if (bus.unsignedLess !== 1'b0) begin n_fail++; $display("FAIL sltu_flag got=%b required 0", bus.unsignedLess); end
    tick(); drive('0, 1'b0);
    repeat (3) tick();
    n_tests++; if (bus.a0 !== 32'd1) begin n_fail++; $display("FAIL slt_result got=%h required 1", bus.a0); end
    issue(alu_rr(5'd10, 5'd1, 5'd2, 4'b0110));
    repeat (3) tick();
    n_tests++; if (bus.a0 !== 32'd0) begin n_fail++; $display("FAIL sltu_result got=%h required 0", bus.a0); end
    issue(alu_ri(5'd8, 5'd0, 32'h80000000, 4'b0000));
    issue(alu_ri(5'd10, 5'd8, 32'd4, 4'b1001));
    repeat (3) tick();
    n_tests++; if (bus.a0 !== 32'hF8000000) begin n_fail++; $display("FAIL sra_result got=%h required f8000000", bus.a0); end
  endtask

  task automatic test_mid_reset();
    issue(alu_ri(5'd10, 5'd0, 32'd9, 4'b0000));
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_retire_in_reset got=%b required 0", bus.retire_valid); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_retire cycle %0d got=%b required 0", c, bus.retire_valid); end
      n_tests++; if (bus.a0 !== 32'd0) begin n_fail++; $display("FAIL midrst_a0 cycle %0d got=%h required 0", c, bus.a0); end
      tick();
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i = '0;
    int kind = $urandom_range(0, 9);
    i.rs1 = 5'($urandom_range(0, 15));
    i.rs2 = 5'($urandom_range(0, 15));
    i.rd  = 5'($urandom_range(0, 15));
    i.pc4 = $urandom;
    if (kind < 2) begin
      i = ld(i.rd, 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      i.rs2 = 5'($urandom_range(0, 15));
    end else if (kind < 4) begin
      i = st(i.rs2, 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
    end else begin
      i.aluc     = 4'($urandom_range(0, 15));
      i.alusrc   = 1'($urandom_range(0, 1));
      i.imm      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      i.regwrite = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0: i.rsrc = 2'b00;
        1: i.rsrc = 2'b10;
        default: i.rsrc = 2'b11;
      endcase
    end
    return i;
  endfunction

  task automatic test_random();
    instr_t prog[$];
    logic [31:0] a0_hist[$];
    bit acc_hist[$];
    instr_t cur;
    logic valid, holding, acc, exp_ready;
    logic [4:0] prev_ld;
    logic [31:0] sa, sb;
    int cyc, drain;

    rst = 1'b1; drive('0, 1'b0);
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) mr[r] = 32'd0;
    for (int w = 0; w < 16; w++) begin
      prog.push_back(alu_ri(5'd9, 5'd0, $urandom, 4'b0000));
      prog.push_back(st(5'd9, 32'(4 * w), 2'b10));
    end
    for (int n = 0; n < 400; n++) prog.push_back(rand_instr());
    for (int r = 1; r < 16; r++) prog.push_back(alu_rr(5'd10, 5'(r), 5'd0, 4'b0000));

    repeat (3) a0_hist.push_back(32'd0);
    repeat (2) acc_hist.push_back(1'b0);
    holding = 1'b0; valid = 1'b0; prev_ld = 5'd0; cyc = 0; drain = 0;

    while ((prog.size() > 0 || drain < 6) && cyc < 5000) begin
      if (!holding) valid = (prog.size() > 0) && ($urandom_range(0, 3) != 0);
      cur = (prog.size() > 0) ? prog[0] : '0;
      drive(cur, valid);
      @(negedge clk);
      exp_ready = !(valid && prev_ld != 5'd0 && (cur.rs1 == prev_ld || cur.rs2 == prev_ld));
      n_tests++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready cycle %0d got=%b required %b", cyc, bus.in_ready, exp_ready); end
      n_tests++; if (bus.retire_valid !== acc_hist[cyc]) begin n_fail++; $display("FAIL rand_retire cycle %0d got=%b required %b", cyc, bus.retire_valid, acc_hist[cyc]); end
      n_tests++; if (bus.a0 !== a0_hist[cyc]) begin n_fail++; $display("FAIL rand_a0 cycle %0d got=%h required %h", cyc, bus.a0, a0_hist[cyc]); end
      acc = valid && (bus.in_ready === 1'b1);
      if (acc) begin
        sa = reg_val(cur.rs1);
        sb = cur.alusrc ? cur.imm : reg_val(cur.rs2);
        n_tests++;
        if (bus.Zero !== (sa == sb) || bus.signedLess !== ($signed(sa) < $signed(sb)) ||
            bus.unsignedLess !== (sa < sb)) begin
          n_fail++;
          $display("FAIL rand_flags cycle %0d got=%b%b%b required %b%b%b", cyc, bus.Zero,
                   bus.signedLess, bus.unsignedLess, sa == sb, $signed(sa) < $signed(sb), sa < sb);
        end
        model_exec(cur);
        void'(prog.pop_front());
        prev_ld = (cur.rsrc == 2'b01 && cur.regwrite) ? cur.rd : 5'd0;
        holding = 1'b0;
      end else begin
        prev_ld = 5'd0;
        holding = valid;
      end
      a0_hist.push_back(mr[10]);
      acc_hist.push_back(acc);
      if (prog.size() == 0) drain++;
      cyc++;
      tick();
    end
    n_tests++; if (cyc >= 5000) begin n_fail++; $display("FAIL rand_budget cycles=%0d required <5000", cyc); end
    drive('0, 1'b0);
  endtask

  initial begin
    drive('0, 1'b0);
    test_reset();
    test_addi_a0();
    test_forward();
    test_loads();
    test_load_use();
    test_compare_shift();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exec_pipe.md
# exec_pipe

Parametrised three-stage execute/memory/writeback datapath: register file, ALU, byte-addressed data memory and result mux, pipelined as E→M→W. Operand forwarding, a one-cycle load-use stall and a valid/ready input handshake are built in. Sits behind the decode stage: it consumes one decoded instruction per cycle and returns branch flags for the instruction currently in E.

## Interface
- XLEN, 32: datapath width (≥32, multiple of 8)
- NREGS, 32: register count; RAW = $clog2(NREGS)
- DMEM_WORDS, 1024: data memory depth in XLEN/8-byte words; power of two
- A0_IDX, 10: register index mirrored on `a0`
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  E stage accepts this cycle; 0 only during load-use stall
- rs1, rs2, rd  in  RAW  source/destination register indices
- RegWrite  in  1  write rd in W
- ALUSrc  in  1  0: SrcB = rs2 value, 1: SrcB = ImmExt
- ALUControl  in  4  ALU operation
- ImmExt  in  XLEN  extended immediate
- MemWrite  in  1  store
- PCPlus4  in  XLEN  link value
- LoadSign  in  1  1: sign-extend loads, 0: zero-extend
- SizeSrc  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ResultSrc  in  2  00 ALU, 01 memory, 10 PCPlus4, 11 ALU
- Zero, signedLess, unsignedLess  out  1  comparison flags for E operands, combinational
- retire_valid  out  1  W stage holds a valid instruction this cycle
- a0  out  XLEN  register A0_IDX contents, registered

## Operation
- ALUControl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass SrcB, all others produce 0.
- Shift amount = SrcB[$clog2(XLEN)-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
- Flags compare post-forwarding SrcA with SrcB.
  - Zero = (SrcA == SrcB).
  - signedLess = signed SrcA < SrcB.
  - unsignedLess = unsigned SrcA < SrcB.
  - Flags are meaningful only when in_valid && in_ready.
- Register x0 reads 0. Writes to x0 are dropped, and rd = 0 never forwards.
- Forwarding for rs1 and rs2, highest priority first:
  1. M stage if M valid, RegWrite, rd ≠ 0 and rd match. Value is the M result selected by ResultSrc (ALU or PCPlus4).
  2. W stage under the same conditions. Value is the final W result, including load data.
  3. Register file.
- Store data = forwarded rs2 value, captured into M.
- Load-use stall: M holds a valid load (ResultSrc = 01, RegWrite, rd ≠ 0) and in_valid with rs1 == M.rd or rs2 == M.rd. The rs2 match applies regardless of ALUSrc.
  - During a stall: in_ready = 0, E is not advanced, and a bubble enters M.
  - The stall lasts exactly one cycle.
- Memory is byte-addressed; byte address = ALUResult. Word index = address bits above log2(XLEN/8), modulo DMEM_WORDS.
  - Word access ignores the low offset bits.
  - Half access uses offset rounded down to even.
  - Byte access uses the full offset.
  - Little-endian.
- Stores write only the addressed bytes.
- Loads read the word synchronously at the end of M. W selects and extends the addressed byte/half using the stored offset, LoadSign and SizeSrc.
- Reset:
  - All stage valids are cleared.
  - All registers are cleared to 0, so a0 = 0.
  - Memory contents are retained.
  - No register or memory write occurs in any cycle where rst = 1.
  - Outputs during/after reset: in_ready = 1, retire_valid = 0.

## Timing
- Instruction accepted at edge ending cycle t (in_valid && in_ready).
  - It is in E during cycle t; flags are valid in cycle t.
  - It is in M in cycle t+1; a store commits at the end of t+1.
  - It is in W in cycle t+2; retire_valid = 1, and the register write commits at the end of t+2.
  - a0 reflects the write from cycle t+3.
- Back-to-back dependent ALU ops issue with no stall. A load followed immediately by a consumer costs exactly 1 bubble.
- Store then load to the same address on consecutive cycles returns the new data.
- rst asserted mid-stream discards E/M/W contents. Instructions accepted 0–2 cycles earlier never write.

## Test plan
- Reset, then ADDI x10,x0,5 (ALUSrc = 1, ImmExt = 5, ALUControl = 0000) -> retire_valid in cycle 3, a0 = 5 from cycle 4.
- ADDI x1,x0,7 followed by SUB x2,x1,x1 on consecutive cycles -> no stall; Zero = 1 while SUB is in E; x2 = 0.
- SW 0xA1B2C3D4 to address 8, then LBU x3 from address 9, LB x4 from address 11, LH x5 from address 10 -> x3 = 0xC3, x4 = 0xFFFFFFA1, x5 = 0xFFFFA1B2.
- LW x6 from address 8, then immediately ADD x10,x6,x0 -> in_ready = 0 for exactly 1 cycle; a0 = 0xA1B2C3D4.
- SLT and SLTU with x1 = 0xFFFFFFFF and x2 = 1 -> signedLess = 1, unsignedLess = 0; results 1 and 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- Issue ADDI x10,x0,9, then assert rst one cycle later for 1 cycle -> a0 stays 0 and no retire_valid occurs.
